// File: rtl/usart_tx.sv
// usart_fifo: circular-buffer word queue with registered occupancy count.
// Latency: a written word is visible at rd_dat one cycle after the accepting edge.
// Backpressure: wr_rdy is low while full; a same-cycle read does not free the slot early.
module usart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != FULL);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
endmodule

// usart_tx: queues parallel words and serialises them as start/data(LSB first)/stop frames.
// Latency: tx falls one cycle after a word is accepted into an idle, empty transmitter.
// Backpressure: ready drops while the queue is full; words offered then are dropped.
module usart_tx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          clk_cnt, clk_cnt_nxt;
    logic [3:0]             bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0]   shift, shift_nxt;
    logic [DATA_BITS-1:0]   head;
    logic                   tx_nxt;
    logic                   done_nxt;
    logic                   pop;
    logic                   bit_end;
    logic                   queued;

    usart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_dat (data),
        .wr_vld (valid),
        .wr_rdy (ready),
        .rd_en  (pop),
        .rd_dat (head),
        .count  (fifo_count)
    );

    assign queued  = (fifo_count != '0);
    assign bit_end = (clk_cnt == CLK_LAST);
    assign busy    = (state != IDLE) || queued;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
            done    <= done_nxt;
        end
    end

    // tx is registered, so it is driven from the state being entered, not the current one.
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        tx_nxt      = tx;
        done_nxt    = 1'b0;
        pop         = 1'b0;

        if (state != IDLE) begin
            clk_cnt_nxt = bit_end ? '0 : clk_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (queued) begin
                    pop         = 1'b1;
                    shift_nxt   = head;
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = START;
                    tx_nxt      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                        tx_nxt      = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        tx_nxt      = shift_nxt[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        done_nxt    = 1'b1;
                        bit_cnt_nxt = '0;
                        // A queued word chains straight into its start bit.
                        if (queued) begin
                            pop       = 1'b1;
                            shift_nxt = head;
                            state_nxt = START;
                            tx_nxt    = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx: BIT_CLKS=10 instances (8N1 and 7N2); a line decoder checks
// every frame of the 8N1 instance against a queue of accepted words.
module tb_usart_tx;
    localparam int CF = 1000000;
    localparam int BR = 100000;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, valid_a, ready_a, tx_a, busy_a, done_a;
    logic [7:0] data_a;
    logic [2:0] fifo_count_a;
    logic       reset_b, valid_b, ready_b, tx_b, busy_b, done_b;
    logic [6:0] data_b;
    logic [2:0] fifo_count_b;

    usart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset_a), .data(data_a), .valid(valid_a), .ready(ready_a),
        .tx(tx_a), .busy(busy_a), .done(done_a), .fifo_count(fifo_count_a));

    usart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset_b), .data(data_b), .valid(valid_b), .ready(ready_b),
        .tx(tx_b), .busy(busy_b), .done(done_b), .fifo_count(fifo_count_b));

    int         checks = 0;
    int         failures = 0;
    int         frames_seen = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] word;
        logic       exp_rdy;
        int         exp_cnt;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_in_time"}, (n < 3000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Line decoder for dut_a: offset 0 is the first start-bit cycle, sampling mid-bit.
    initial begin : mon_a
        logic [7:0] got;
        logic [7:0] exp;
        bit         have_start;
        have_start = 1'b0;
        forever begin
            if (!have_start) @(negedge clk);
            have_start = 1'b0;
            if (mon_en && tx_a === 1'b0) begin
                repeat (5) @(negedge clk);
                check("mon_start_bit", tx_a, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    got[i] = tx_a;
                end
                repeat (10) @(negedge clk);
                check("mon_stop_bit", tx_a, 1);
                repeat (4) @(negedge clk);
                check("mon_done_early", done_a, 0);
                @(negedge clk);
                check("mon_done_at_100", done_a, 1);
                frames_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected_frame: got %0h expected no frame", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("mon_word", got, exp);
                end
                if (tx_a === 1'b0) have_start = 1'b1;
            end
        end
    end

    initial begin : main
        vec_t       tbl[6];
        logic [0:9] pat;
        int         bad, ndone, off, f0, sent, guard;
        logic       accept;

        tbl[0] = '{8'h00, 1'b1, 1};
        tbl[1] = '{8'h01, 1'b1, 1};   // pushed on the edge that pops 0x00
        tbl[2] = '{8'h02, 1'b1, 2};
        tbl[3] = '{8'h03, 1'b1, 3};
        tbl[4] = '{8'h04, 1'b1, 4};
        tbl[5] = '{8'h05, 1'b0, 4};   // full: dropped

        reset_a = 1'b1; reset_b = 1'b1;
        valid_a = 1'b1; valid_b = 1'b0;
        data_a  = 8'h77; data_b = 7'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_done", done_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_count_push_ignored", fifo_count_a, 0);
        check("rst_b_tx", tx_b, 1);
        check("rst_b_count", fifo_count_b, 0);
        valid_a = 1'b0;
        reset_a = 1'b0; reset_b = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Single 0xA5 frame; data changes right after acceptance.
        pat = 10'b0101001011;
        f0 = frames_seen;
        exp_q.push_back(8'hA5);
        data_a = 8'hA5; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0; data_a = 8'h00;
        check("a5_count_after_push", fifo_count_a, 1);
        check("a5_tx_still_idle", tx_a, 1);
        @(negedge clk);
        bad = 0;
        for (int o = 0; o < 100; o++) begin
            if (tx_a !== pat[o / 10]) bad++;
            if (done_a !== 1'b0) bad++;
            @(negedge clk);
        end
        check("a5_waveform_errors", bad, 0);
        check("a5_done", done_a, 1);
        check("a5_busy_drop", busy_a, 0);
        @(negedge clk);
        check("a5_done_one_cycle", done_a, 0);
        wait_idle("a5");
        check("a5_frames", frames_seen - f0, 1);

        // Streaming: six consecutive pushes with valid held.
        f0 = frames_seen;
        valid_a = 1'b1;
        for (int j = 0; j < 6; j++) begin
            data_a = tbl[j].word;
            check("stream_ready", ready_a, tbl[j].exp_rdy);
            if (tbl[j].exp_rdy) exp_q.push_back(tbl[j].word);
            @(negedge clk);
            check("stream_count", fifo_count_a, tbl[j].exp_cnt);
        end
        valid_a = 1'b0;
        off = 4; ndone = 0; bad = 0;
        repeat (506) begin
            @(negedge clk);
            off++;
            if (done_a === 1'b1) ndone++;
            if (done_a !== ((off % 100 == 0) && off <= 500)) bad++;
        end
        check("stream_done_timing_errors", bad, 0);
        check("stream_done_count", ndone, 5);
        wait_idle("stream");
        check("stream_frames", frames_seen - f0, 5);
        check("stream_queue_drained", exp_q.size(), 0);

        // Reset during the third data bit of 0x0F with 0xF0 queued.
        mon_en = 1'b0;
        data_a = 8'h0F; valid_a = 1'b1;
        @(negedge clk);
        data_a = 8'hF0;
        @(negedge clk);
        valid_a = 1'b0;
        check("rstmid_count_queued", fifo_count_a, 1);
        repeat (32) @(negedge clk);
        check("rstmid_bit2", tx_a, 1);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        check("rstmid_tx", tx_a, 1);
        check("rstmid_count", fifo_count_a, 0);
        check("rstmid_busy", busy_a, 0);
        check("rstmid_done", done_a, 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        check("rstmid_quiet_errors", bad, 0);
        mon_en = 1'b1;

        // Push coinciding with the pop at the end of a stop bit.
        f0 = frames_seen;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
        data_a = 8'hFF; valid_a = 1'b1;
        @(negedge clk);
        data_a = 8'h00;
        @(negedge clk);
        data_a = 8'h5A;
        @(negedge clk);
        valid_a = 1'b0;
        check("simul_count_before", fifo_count_a, 2);
        repeat (98) @(negedge clk);
        check("simul_count_pre_edge", fifo_count_a, 2);
        check("simul_done_pre_edge", done_a, 0);
        data_a = 8'hC3; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check("simul_count_after", fifo_count_a, 2);
        check("simul_done", done_a, 1);
        wait_idle("simul");
        check("simul_frames", frames_seen - f0, 4);

        // Pointer wrap: 12 words pushed whenever ready.
        f0 = frames_seen;
        sent = 0; guard = 0; bad = 0;
        data_a = 8'h10; valid_a = 1'b1;
        while (sent < 12 && guard < 5000) begin
            accept = ready_a;
            if (accept) exp_q.push_back(data_a);
            @(negedge clk);
            guard++;
            if (fifo_count_a > 3'd4) bad++;
            if (accept) begin
                sent++;
                data_a = 8'h10 + 8'(sent);
            end
        end
        valid_a = 1'b0;
        check("wrap_all_accepted", sent, 12);
        while (busy_a === 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (fifo_count_a > 3'd4) bad++;
        end
        check("wrap_count_limit_errors", bad, 0);
        wait_idle("wrap");
        check("wrap_frames", frames_seen - f0, 12);
        check("wrap_queue_drained", exp_q.size(), 0);

        // 7 data bits, 2 stop bits on dut_b.
        data_b = 7'h7F; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        check("b_count_after_push", fifo_count_b, 1);
        @(negedge clk);
        bad = 0;
        for (int o = 0; o < 100; o++) begin
            if (tx_b !== ((o >= 10) ? 1'b1 : 1'b0)) bad++;
            if (done_b !== 1'b0) bad++;
            @(negedge clk);
        end
        check("b_waveform_errors", bad, 0);
        check("b_done", done_b, 1);
        check("b_busy_drop", busy_b, 0);
        @(negedge clk);
        check("b_done_one_cycle", done_b, 0);
        check("b_tx_idle", tx_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usart_tx.md
# usart_tx

Serial transmitter for the USART block set. It accepts parallel words over a valid/ready handshake into a small internal FIFO and serialises each word onto `tx` as an asynchronous frame: one start bit, DATA_BITS data bits LSB first, then STOP_BITS stop bits, with no parity. It is the transmit-side counterpart to the USART receiver and uses the same CLK_FREQ, BAUD_RATE and frame parameters, so the two interoperate when configured identically.

## Interface
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. BIT_CLKS = CLK_FREQ / BAUD_RATE, using integer division; must be ≥ 2.
- DATA_BITS, 8: data bits per frame, from 5 to 9.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; must be a power of two, ≥ 2.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  DATA_BITS  word to transmit.
- valid  input  1  `data` is presented this cycle.
- ready  output  1  FIFO can accept a word; equals (count != FIFO_DEPTH).
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high when state != IDLE or the FIFO is non-empty.
- done  output  1  one-cycle pulse when the final stop bit of a frame completes.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words queued.

## Operation
- Push:
  - A word is written when valid && ready at a rising edge.
  - valid while not ready: the word is dropped and nothing changes.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Simultaneous push and pop: count unchanged.
  - Full: ready = 0. A pop in the same cycle does not re-enable that cycle's push.
- State machine: IDLE, START, DATA, STOP. A bit counter (0..DATA_BITS-1, or 0..STOP_BITS-1 in STOP) and a clock counter (0..BIT_CLKS-1) advance the states.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, clear the counters, and go to START.
  - START: tx = 0 for BIT_CLKS cycles, then go to DATA.
  - DATA: tx = shift register bit 0. Every BIT_CLKS cycles, shift right and increment the bit counter. After DATA_BITS bits, go to STOP.
  - STOP: tx = 1 for STOP_BITS × BIT_CLKS cycles. On the final cycle, assert done next cycle. Then:
    - FIFO non-empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- Counters never exceed BIT_CLKS-1. The clock counter width is $clog2(BIT_CLKS), minimum 1.
- Reset values: tx = 1, done = 0, ready = 1, busy = 0, fifo_count = 0, state = IDLE, all pointers and counters 0.
- Reset mid-frame: the frame is abandoned and the FIFO is flushed. tx returns to 1 on the first cycle after the reset edge. done is not pulsed for the abandoned frame.
- While reset is high, pushes are ignored.
- `data` is sampled only at the accepting edge; later changes do not affect queued words.

## Timing
- Latency:
  - Word accepted at edge k while in IDLE with an empty FIFO: fifo_count = 1 after edge k.
  - The pop occurs at edge k+1; tx = 0 from edge k+1.
  - The first data bit starts at edge k+1+BIT_CLKS.
- Frame length: (1 + DATA_BITS + STOP_BITS) × BIT_CLKS cycles. Every bit is exactly BIT_CLKS cycles, with no jitter.
- Back-to-back words produce contiguous frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- done is high for exactly one cycle: the first cycle after the last stop-bit cycle. This coincides with the next frame's first start-bit cycle when streaming.
- ready and fifo_count reflect the registered count: combinational from state, no input-to-output path.
- busy falls in the same cycle done rises when the FIFO is empty.

## Test plan
- Single frame, CLK_FREQ=1000000, BAUD_RATE=100000 (BIT_CLKS=10), push 0xA5:
  - tx low 10 cycles starting 1 cycle after the push.
  - Then 1,0,1,0,0,1,0,1, each held 10 cycles.
  - Then high 10 cycles.
  - done pulses once, 100 cycles after tx first goes low.
  - busy then drops.
- Streaming: push 6 words, 0x00–0x05, on consecutive cycles with valid held:
  - Words 0x00–0x04 are accepted; ready = 0 on the 6th cycle and word 0x05 is dropped.
  - 5 contiguous 100-cycle frames are sent in order.
  - done pulses 5 times, 100 cycles apart.
- STOP_BITS=2, DATA_BITS=7, push 0x7F: frame = 0, seven 1s, then 20 cycles high. done fires at cycle 100 of the frame.
- Reset mid-frame: push 0x0F and 0xF0, then assert reset during the third data bit of the first frame.
  - tx = 1 the cycle after reset.
  - fifo_count = 0 and no done pulse.
  - No frame follows until a new push.
- Simultaneous push/pop: with FIFO_DEPTH=4 and 2 words queued, push on the exact cycle of a pop (end of stop bit). fifo_count stays at 2 and ordering is preserved.
- Pointer wrap: stream 12 words, 0x10–0x1B, pushing whenever ready. All 12 are transmitted in order; fifo_count never exceeds 4.
